// File: rtl/video_mixer_pkg.sv
// Shared definitions for the video mixer: register addresses, fade trigger
// codes, fade state encoding, priority modes and the brightness ceiling.
package video_mixer_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_BG    = 2'd1;
  localparam logic [1:0] ADDR_FADE  = 2'd2;
  localparam logic [1:0] ADDR_SPEED = 2'd3;

  localparam logic [7:0] TRIG_IDLE = 8'd0;
  localparam logic [7:0] TRIG_OUT  = 8'd1;
  localparam logic [7:0] TRIG_IN   = 8'd2;

  localparam logic [1:0] MODE_SCT = 2'd0;  // sprite > charmap > tilemap
  localparam logic [1:0] MODE_CST = 2'd1;  // charmap > sprite > tilemap
  localparam logic [1:0] MODE_STC = 2'd2;  // sprite > tilemap > charmap
  localparam logic [1:0] MODE_TSC = 2'd3;  // tilemap > sprite > charmap

  localparam logic [4:0] BRIGHT_MAX = 5'd16;
  localparam logic [4:0] CTRL_RESET = 5'h1C;  // mode 0, all layers enabled

  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_OUT  = 2'd1,
    FADE_IN   = 2'd2
  } fade_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // RGB332 to RGB888 by bit replication.
  function automatic rgb_t expand_bg(input logic [7:0] c);
    rgb_t o;
    o.r = {c[7:5], c[7:5], c[7:6]};
    o.g = {c[4:2], c[4:2], c[4:3]};
    o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/video_mixer_scale.sv
// mixer_scale: combinational per-channel brightness scaler.
//   color  in  8  channel value
//   bright in  5  brightness 0..16
//   scaled out 8  (color * bright) >> 4
module mixer_scale (
  input  logic [7:0] color,
  input  logic [4:0] bright,
  output logic [7:0] scaled
);

  logic [12:0] prod;

  always_comb begin
    prod   = 13'(color) * 13'(bright);
    scaled = 8'(prod >> 4);
  end

endmodule

// File: rtl/video_mixer.sv
// video_mixer: three-layer priority mixer with background fill, global
// brightness fade and CPU control registers.
//   clk, reset                  clock / sync active-high reset
//   pause                       freezes fade progression
//   hblank, vblank              raw blanking aligned with layer pixels
//   addr, data_in, write        CPU register write port
//   mixercontrol_data_out       combinational readback of register[addr]
//   tilemap/charmap/sprite_*    layer pixels (r,g,b 8-bit, a 1-bit)
//   video_r/g/b                 mixed pixel, 2-cycle latency
//   video_hblank/vblank         blanking delayed 2 cycles
module video_mixer
  import video_mixer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic [7:0] mixercontrol_data_out,
  input  logic [7:0] tilemap_r,
  input  logic [7:0] tilemap_g,
  input  logic [7:0] tilemap_b,
  input  logic       tilemap_a,
  input  logic [7:0] charmap_r,
  input  logic [7:0] charmap_g,
  input  logic [7:0] charmap_b,
  input  logic       charmap_a,
  input  logic [7:0] sprite_r,
  input  logic [7:0] sprite_g,
  input  logic [7:0] sprite_b,
  input  logic       sprite_a,
  output logic [7:0] video_r,
  output logic [7:0] video_g,
  output logic [7:0] video_b,
  output logic       video_hblank,
  output logic       video_vblank
);

  logic [7:0]  ctrl_reg, bg_reg, fade_reg, speed_reg;
  logic [4:0]  ctrl_active;
  logic        vblank_prev;
  logic        vblank_rise, vblank_fall;

  fade_state_t fade_state, state_nxt;
  logic [4:0]  brightness, bright_nxt;
  logic [7:0]  frame_cnt, cnt_nxt, fade_reg_nxt, limit;
  logic        step, done;

  rgb_t        pick, s1_pix, scaled;
  logic        s1_hb, s1_vb;
  logic        t_ok, c_ok, s_ok;
  rgb_t        tile_pix, char_pix, spr_pix;

  assign vblank_rise = vblank & ~vblank_prev;
  assign vblank_fall = ~vblank & vblank_prev;

  always_comb begin
    mixercontrol_data_out = '0;
    case (addr)
      ADDR_CTRL:  mixercontrol_data_out = ctrl_reg;
      ADDR_BG:    mixercontrol_data_out = bg_reg;
      ADDR_FADE:  mixercontrol_data_out = fade_reg;
      ADDR_SPEED: mixercontrol_data_out = speed_reg;
      default:    mixercontrol_data_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg    <= '0;
      bg_reg      <= '0;
      speed_reg   <= '0;
      ctrl_active <= CTRL_RESET;
      vblank_prev <= 1'b0;
    end else begin
      vblank_prev <= vblank;
      if (write && addr == ADDR_CTRL)  ctrl_reg  <= data_in;
      if (write && addr == ADDR_BG)    bg_reg    <= data_in;
      if (write && addr == ADDR_SPEED) speed_reg <= data_in;
      if (vblank_fall) ctrl_active <= ctrl_reg[4:0];
    end
  end

  // Fade FSM. Register 2 is owned here: stored only while idle, and cleared
  // on completion; trigger writes are ignored while fading, so the clear
  // always takes precedence over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      fade_state <= FADE_IDLE;
      brightness <= BRIGHT_MAX;
      frame_cnt  <= '0;
      fade_reg   <= '0;
    end else begin
      fade_state <= state_nxt;
      brightness <= bright_nxt;
      frame_cnt  <= cnt_nxt;
      fade_reg   <= fade_reg_nxt;
    end
  end

  always_comb begin
    state_nxt    = fade_state;
    bright_nxt   = brightness;
    cnt_nxt      = frame_cnt;
    fade_reg_nxt = fade_reg;
    step         = 1'b0;
    done         = 1'b0;
    limit        = (speed_reg == 8'd0) ? 8'd1 : speed_reg;
    case (fade_state)
      FADE_IDLE: begin
        if (write && addr == ADDR_FADE) begin
          fade_reg_nxt = data_in;
          if (data_in == TRIG_OUT) begin
            state_nxt = FADE_OUT;
            cnt_nxt   = '0;
          end else if (data_in == TRIG_IN) begin
            state_nxt = FADE_IN;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        if (vblank_rise && !pause) begin
          if (frame_cnt + 8'd1 >= limit) begin
            cnt_nxt = '0;
            step    = 1'b1;
          end else begin
            cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end
    endcase
    if (step) begin
      if (fade_state == FADE_OUT) begin
        if (brightness != 5'd0) bright_nxt = brightness - 5'd1;
        done = (brightness <= 5'd1);
      end else begin
        if (brightness < BRIGHT_MAX) bright_nxt = brightness + 5'd1;
        done = (brightness >= BRIGHT_MAX - 5'd1);
      end
    end
    if (done) begin
      state_nxt    = FADE_IDLE;
      fade_reg_nxt = '0;
    end
  end

  // Stage 1: priority select.
  assign t_ok     = tilemap_a & ctrl_active[2];
  assign c_ok     = charmap_a & ctrl_active[3];
  assign s_ok     = sprite_a  & ctrl_active[4];
  assign tile_pix = '{tilemap_r, tilemap_g, tilemap_b};
  assign char_pix = '{charmap_r, charmap_g, charmap_b};
  assign spr_pix  = '{sprite_r, sprite_g, sprite_b};

  always_comb begin
    pick = expand_bg(bg_reg);
    case (ctrl_active[1:0])
      MODE_SCT: if (s_ok) pick = spr_pix;  else if (c_ok) pick = char_pix; else if (t_ok) pick = tile_pix;
      MODE_CST: if (c_ok) pick = char_pix; else if (s_ok) pick = spr_pix;  else if (t_ok) pick = tile_pix;
      MODE_STC: if (s_ok) pick = spr_pix;  else if (t_ok) pick = tile_pix; else if (c_ok) pick = char_pix;
      MODE_TSC: if (t_ok) pick = tile_pix; else if (s_ok) pick = spr_pix;  else if (c_ok) pick = char_pix;
      default:  pick = expand_bg(bg_reg);
    endcase
  end

  // Stage 2: brightness scaling and blanking.
  mixer_scale u_scale_r (.color(s1_pix.r), .bright(brightness), .scaled(scaled.r));
  mixer_scale u_scale_g (.color(s1_pix.g), .bright(brightness), .scaled(scaled.g));
  mixer_scale u_scale_b (.color(s1_pix.b), .bright(brightness), .scaled(scaled.b));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_pix       <= '0;
      s1_hb        <= 1'b1;
      s1_vb        <= 1'b1;
      video_r      <= '0;
      video_g      <= '0;
      video_b      <= '0;
      video_hblank <= 1'b1;
      video_vblank <= 1'b1;
    end else begin
      s1_pix       <= pick;
      s1_hb        <= hblank;
      s1_vb        <= vblank;
      video_hblank <= s1_hb;
      video_vblank <= s1_vb;
      if (s1_hb || s1_vb) begin
        video_r <= '0;
        video_g <= '0;
        video_b <= '0;
      end else begin
        video_r <= scaled.r;
        video_g <= scaled.g;
        video_b <= scaled.b;
      end
    end
  end

endmodule

// File: tb/tb_video_mixer.sv
// Directed self-checking bench for video_mixer.
module tb_video_mixer;
  import video_mixer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, pause, hblank, vblank, write;
  logic [1:0] addr;
  logic [7:0] data_in, rd;
  logic [7:0] tilemap_r, tilemap_g, tilemap_b, charmap_r, charmap_g, charmap_b;
  logic [7:0] sprite_r, sprite_g, sprite_b;
  logic       tilemap_a, charmap_a, sprite_a;
  logic [7:0] video_r, video_g, video_b;
  logic       video_hblank, video_vblank;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  video_mixer dut (
    .clk(clk), .reset(reset), .pause(pause), .hblank(hblank), .vblank(vblank),
    .addr(addr), .data_in(data_in), .write(write), .mixercontrol_data_out(rd),
    .tilemap_r(tilemap_r), .tilemap_g(tilemap_g), .tilemap_b(tilemap_b), .tilemap_a(tilemap_a),
    .charmap_r(charmap_r), .charmap_g(charmap_g), .charmap_b(charmap_b), .charmap_a(charmap_a),
    .sprite_r(sprite_r), .sprite_g(sprite_g), .sprite_b(sprite_b), .sprite_a(sprite_a),
    .video_r(video_r), .video_g(video_g), .video_b(video_b),
    .video_hblank(video_hblank), .video_vblank(video_vblank)
  );

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; data_in = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rdreg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, 32'(rd), 32'(exp));
  endtask

  // One vblank pulse followed by enough idle cycles for the pipeline to clear.
  task automatic vpulse(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick(3);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    check(tag, {8'h0, video_r, video_g, video_b}, {8'h0, r, g, b});
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; hblank = 1'b0; vblank = 1'b0; write = 1'b0;
    addr = '0; data_in = '0;
    {tilemap_r, tilemap_g, tilemap_b, tilemap_a} = '0;
    {charmap_r, charmap_g, charmap_b, charmap_a} = '0;
    {sprite_r, sprite_g, sprite_b, sprite_a} = '0;
    tick(2);

    // Reset state
    check_rgb("reset_rgb", 8'd0, 8'd0, 8'd0);
    check("reset_hblank", 32'(video_hblank), 32'd1);
    check("reset_vblank", 32'(video_vblank), 32'd1);
    rdreg("reset_reg0", ADDR_CTRL, 8'h00);
    rdreg("reset_reg2", ADDR_FADE, 8'h00);
    reset = 1'b0;

    // Sprite over tilemap in mode 0 at full brightness
    tilemap_r = 8'd10; tilemap_g = 8'd20; tilemap_b = 8'd30; tilemap_a = 1'b1;
    sprite_r = 8'd200; sprite_g = 8'd0; sprite_b = 8'd0; sprite_a = 1'b1;
    tick(2);
    check_rgb("mode0_sprite", 8'd200, 8'd0, 8'd0);
    check("hblank_delay_low", 32'(video_hblank), 32'd0);

    // Mode 3 written mid-frame takes effect only after vblank falls
    wr(ADDR_CTRL, 8'h1F);
    tick(3);
    check_rgb("mode3_midframe_held", 8'd200, 8'd0, 8'd0);
    vblank = 1'b1;
    tick(2);
    check_rgb("vblank_blanked", 8'd0, 8'd0, 8'd0);
    vblank = 1'b0;
    tick(3);
    check_rgb("mode3_after_vblank", 8'd10, 8'd20, 8'd30);

    // Charmap has lowest priority in mode 3; tilemap still wins
    charmap_r = 8'd1; charmap_g = 8'd2; charmap_b = 8'd3; charmap_a = 1'b1;
    tick(2);
    check_rgb("mode3_tile_over_char", 8'd10, 8'd20, 8'd30);

    // Background fill when no layer qualifies
    tilemap_a = 1'b0; charmap_a = 1'b0; sprite_a = 1'b0;
    wr(ADDR_BG, 8'hE0);
    tick(2);
    check_rgb("bg_red", 8'd255, 8'd0, 8'd0);
    hblank = 1'b1;
    tick(2);
    check_rgb("hblank_black", 8'd0, 8'd0, 8'd0);
    check("hblank_delay_high", 32'(video_hblank), 32'd1);
    hblank = 1'b0;
    tick(2);

    // Fade out, 2 frames per step
    wr(ADDR_SPEED, 8'd2);
    wr(ADDR_FADE, TRIG_OUT);
    check("fade_out_state", 32'(dut.fade_state), 32'(FADE_OUT));
    vpulse(1);
    check_rgb("fade_one_frame", 8'd255, 8'd0, 8'd0);
    vpulse(1);
    check_rgb("fade_b15", 8'd239, 8'd0, 8'd0);

    // Trigger while fading is ignored
    wr(ADDR_FADE, TRIG_IN);
    rdreg("trigger_ignored", ADDR_FADE, TRIG_OUT);
    check("state_after_ignored", 32'(dut.fade_state), 32'(FADE_OUT));

    // Pause holds brightness across 5 frames
    pause = 1'b1;
    vpulse(5);
    check_rgb("pause_hold", 8'd239, 8'd0, 8'd0);
    pause = 1'b0;

    vpulse(29);
    check_rgb("fade_b1", 8'd15, 8'd0, 8'd0);
    vpulse(1);
    check_rgb("fade_b0", 8'd0, 8'd0, 8'd0);
    rdreg("fade_done_reg2", ADDR_FADE, 8'h00);
    check("fade_done_idle", 32'(dut.fade_state), 32'(FADE_IDLE));

    // Fade out started at brightness 0 completes on the first step, no change
    wr(ADDR_FADE, TRIG_OUT);
    vpulse(1);
    rdreg("zero_fade_pending", ADDR_FADE, TRIG_OUT);
    vpulse(1);
    rdreg("zero_fade_done_reg2", ADDR_FADE, 8'h00);
    check("zero_fade_idle", 32'(dut.fade_state), 32'(FADE_IDLE));
    check("zero_fade_bright", 32'(dut.brightness), 32'd0);

    // Non-trigger value is stored but starts nothing
    wr(ADDR_FADE, 8'd7);
    rdreg("nontrigger_stored", ADDR_FADE, 8'd7);
    check("nontrigger_idle", 32'(dut.fade_state), 32'(FADE_IDLE));

    // Fade in, then reset mid-fade
    wr(ADDR_FADE, TRIG_IN);
    check("fade_in_state", 32'(dut.fade_state), 32'(FADE_IN));
    vpulse(2);
    check_rgb("fade_in_b1", 8'd15, 8'd0, 8'd0);
    reset = 1'b1;
    tick();
    check("reset_mid_bright", 32'(dut.brightness), 32'd16);
    check("reset_mid_state", 32'(dut.fade_state), 32'(FADE_IDLE));
    rdreg("reset_mid_reg0", ADDR_CTRL, 8'h00);
    rdreg("reset_mid_reg1", ADDR_BG, 8'h00);
    rdreg("reset_mid_reg2", ADDR_FADE, 8'h00);
    rdreg("reset_mid_reg3", ADDR_SPEED, 8'h00);
    reset = 1'b0;

    // Active copy restored to all-enabled mode 0 after reset
    sprite_a = 1'b1; tilemap_a = 1'b1;
    tick(2);
    check_rgb("post_reset_sprite", 8'd200, 8'd0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_mixer.md
VIDEO_MIXER -- requirements
Module: video_mixer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock, which also serves as the pixel-rate clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pause  in  1  freezes fade progression only.
REQ-005 hblank, vblank  in  1 each  raw blanking signals, aligned with the layer pixel inputs.
REQ-006 addr  in  2  control register select.
- data_in  in  8  CPU write data.
- write  in  1  single-cycle write strobe.
REQ-007 mixercontrol_data_out  out  8  combinational readback of register[addr].
REQ-008 tilemap_r/g/b  in  8 each, tilemap_a  in  1  tilemap layer pixel.
- charmap_r/g/b  in  8 each, charmap_a  in  1  character layer pixel.
- sprite_r/g/b  in  8 each, sprite_a  in  1  sprite layer pixel.
REQ-009 video_r/g/b  out  8 each  mixed pixel.
- video_hblank, video_vblank  out  1 each  blanking delayed to match the pixel path.

Function
REQ-010 Register map:
- 0 = layer control: [1:0] priority mode, [2] tilemap enable, [3] charmap enable, [4] sprite enable.
- 1 = background colour, RGB332.
- 2 = fade trigger.
- 3 = fade speed, in frames per brightness step.
REQ-011 A CPU write SHALL update register[addr] on the next clock edge.
REQ-012 Priority modes, highest priority first:
- 0: sprite > charmap > tilemap.
- 1: charmap > sprite > tilemap.
- 2: sprite > tilemap > charmap.
- 3: tilemap > sprite > charmap.
REQ-013 Register 0 SHALL be copied to an active copy on the falling edge of vblank; mid-frame writes SHALL NOT affect the current frame.
REQ-014 Stage 1 (one cycle) SHALL register the colour of the highest-priority layer whose alpha is 1 and whose enable bit is set.
- If no layer qualifies, it SHALL register the background colour.
- Background expansion: R = {c[7:5],c[7:5],c[7:6]}, G = {c[4:2],c[4:2],c[4:3]}, B = {c[1:0],c[1:0],c[1:0],c[1:0]}.
REQ-015 Stage 2 (one cycle) SHALL output each channel as (channel × brightness) >> 4.
- brightness is 5 bits, range 0..16.
- Product width is 13 bits.
- brightness 16 SHALL pass the colour unchanged; brightness 0 SHALL output black.
REQ-016 Pixel latency SHALL be exactly 2 cycles.
- video_hblank and video_vblank SHALL be the inputs delayed 2 cycles.
- video_r/g/b SHALL be 0 whenever the delayed hblank or vblank is high.
REQ-017 The fade state machine SHALL have three states: FADE_IDLE, FADE_OUT, FADE_IN.
REQ-018 In FADE_IDLE, writing register 2 with 1 SHALL enter FADE_OUT, and writing 2 SHALL enter FADE_IN.
- Other values SHALL be stored but start nothing.
- On a start, the frame counter SHALL clear to 0.
REQ-019 Trigger writes while FADE_OUT or FADE_IN is active SHALL be ignored, and register 2 SHALL keep its value.
REQ-020 On each vblank rising edge while fading with pause=0, the 8-bit frame counter SHALL increment.
- When it reaches max(register 3, 1), it SHALL reset to 0 and brightness SHALL step by 1 (down in FADE_OUT, up in FADE_IN).
REQ-021 FADE_OUT SHALL complete when brightness reaches 0; FADE_IN SHALL complete when brightness reaches 16.
- On completion: return to FADE_IDLE, clear register 2 to 0, hold brightness.
REQ-022 If FADE_OUT is started at brightness 0, it SHALL complete on the first step edge with no change; FADE_IN at 16 SHALL behave the same way.
REQ-023 When pause=1, the frame counter and brightness SHALL hold, and the pixel pipeline SHALL keep running.
REQ-024 If a CPU write to register 2 and fade completion occur in the same cycle, completion's clear SHALL win.

Reset
REQ-025 Reset SHALL set:
- registers 0..3 to 0;
- the active layer copy to 8'h1C (mode 0, all layers enabled);
- brightness to 16, FADE_IDLE, frame counter 0;
- pipeline registers and video outputs to 0;
- video_hblank and video_vblank to 1.
REQ-026 Reset mid-fade SHALL abort the fade immediately and restore brightness to 16.

Structure
REQ-027 A shared package SHALL hold:
- the register address constants;
- the fade trigger codes (0 idle, 1 out, 2 in);
- the fade state enumeration;
- the priority mode constants;
- BRIGHT_MAX = 16.
REQ-028 The per-channel scaler SHALL be a sub-module, mixer_scale, with 8-bit colour and 5-bit brightness in, 8-bit out, combinational, instantiated three times.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Tile a=1 (10,20,30), sprite a=1 (200,0,0), mode 0, brightness 16 -> output (200,0,0) two cycles later.
- Same inputs, mode 3 written mid-frame -> output stays (200,0,0) until the vblank falling edge, then becomes (10,20,30).
- All alpha=0, register 1 = 8'hE0 -> output (255,0,0); during hblank the output is (0,0,0).
- Register 3 = 2, trigger 1 -> brightness 15 after 2 vblanks; after 32 vblanks brightness is 0, register 2 reads 0, and input 255 outputs 0.
- Trigger 2 written during FADE_OUT -> ignored; pause=1 held for 5 vblanks -> brightness unchanged.
- Reset asserted mid-fade -> next cycle brightness is 16, the state is FADE_IDLE, and all registers read 0.
